// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - execute stage: forwarding, single-cycle ALU, iterative multiply/divide
module ex_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] write_data,
    input  logic [4:0]      rd_in,
    output logic            ex_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic            zero,
    output logic [4:0]      rd_out
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_val, sra_val;
    logic            is_m_enc, is_m_op, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;

    // Operands captured when a multi-cycle op is accepted
    logic [XLEN-1:0] ma, mb, m_store;
    logic [1:0]      m_f3;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] div_rem, div_quo, div_dvs;
    logic            neg_q, neg_r, dbz;
    logic [CW-1:0]   cnt;
    logic            div_last;

    always_comb begin
        case (forwardA)
            2'b10:   fwd_a = ex_mem_alu_result;
            2'b01:   fwd_a = write_data;
            default: fwd_a = rs1_data;
        endcase
        case (forwardB)
            2'b10:   fwd_b = ex_mem_alu_result;
            2'b01:   fwd_b = write_data;
            default: fwd_b = rs2_data;
        endcase
        op_b = alu_src ? imm : fwd_b;
    end

    assign is_m_enc = (alu_op == 2'b10) && (funct7 == 7'b0000001);
    assign is_m_op  = (ENABLE_M != 0) && is_m_enc;
    assign sra_val  = $signed(fwd_a) >>> op_b[SW-1:0];

    always_comb begin
        alu_val = '0;
        if (alu_op == 2'b00) begin
            alu_val = fwd_a + op_b;
        end else if (alu_op == 2'b01) begin
            alu_val = fwd_a - op_b;
        end else if (!is_m_enc) begin
            case (funct3)
                3'b000:  alu_val = (alu_op == 2'b10 && funct7[5]) ? fwd_a - op_b : fwd_a + op_b;
                3'b001:  alu_val = fwd_a << op_b[SW-1:0];
                3'b010:  alu_val = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                3'b011:  alu_val = {{(XLEN-1){1'b0}}, fwd_a < op_b};
                3'b100:  alu_val = fwd_a ^ op_b;
                3'b101:  alu_val = funct7[5] ? sra_val : fwd_a >> op_b[SW-1:0];
                3'b110:  alu_val = fwd_a | op_b;
                default: alu_val = fwd_a & op_b;
            endcase
        end
    end

    // Signed divide works on magnitudes; the unsigned negate of the most-negative value is itself
    assign a_neg = !funct3[0] && fwd_a[XLEN-1];
    assign b_neg = !funct3[0] && op_b[XLEN-1];
    assign abs_a = a_neg ? -fwd_a : fwd_a;
    assign abs_b = b_neg ? -op_b : op_b;

    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0]   mul_val;

    always_comb begin
        a_sgn   = (m_f3 == 2'b01) || (m_f3 == 2'b10);
        b_sgn   = (m_f3 == 2'b01);
        ext_a   = {{XLEN{a_sgn & ma[XLEN-1]}}, ma};
        ext_b   = {{XLEN{b_sgn & mb[XLEN-1]}}, mb};
        prod    = ext_a * ext_b;
        mul_val = (m_f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] rem_step, quo_step, div_q, div_r, div_val;

    assign div_shift = {div_rem, div_quo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, div_dvs};
    assign rem_step  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign quo_step  = {div_quo[XLEN-2:0], ~div_diff[XLEN]};
    assign div_last  = (cnt == CW'(XLEN - 1));

    always_comb begin
        div_q = neg_q ? -quo_step : quo_step;
        div_r = neg_r ? -rem_step : rem_step;
        if (dbz) begin
            div_q = '1;
            div_r = ma;
        end
        div_val = m_f3[1] ? div_r : div_q;
    end

    always_comb begin
        state_next = state;
        ex_stall   = 1'b0;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid && is_m_op) begin
                    state_next = funct3[2] ? S_DIV : S_MUL;
                    ex_stall   = 1'b1;
                end
                S_MUL: state_next = S_IDLE;
                S_DIV: begin
                    if (div_last) state_next = S_IDLE;
                    else          ex_stall   = 1'b1;
                end
                default: state_next = S_IDLE;
            endcase
        end
        if (!rst_n) ex_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            alu_result <= '0;
            store_data <= '0;
            zero       <= 1'b0;
            rd_out     <= '0;
            cnt        <= '0;
            ma         <= '0;
            mb         <= '0;
            m_store    <= '0;
            m_f3       <= '0;
            m_rd       <= '0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_dvs    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: if (in_valid) begin
                        if (is_m_op) begin
                            ma      <= fwd_a;
                            mb      <= op_b;
                            m_store <= fwd_b;
                            m_f3    <= funct3[1:0];
                            m_rd    <= rd_in;
                            div_rem <= '0;
                            div_quo <= abs_a;
                            div_dvs <= abs_b;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            dbz     <= (op_b == '0);
                            cnt     <= '0;
                        end else begin
                            out_valid  <= 1'b1;
                            alu_result <= alu_val;
                            zero       <= (alu_val == '0);
                            rd_out     <= rd_in;
                            store_data <= fwd_b;
                        end
                    end
                    S_MUL: begin
                        out_valid  <= 1'b1;
                        alu_result <= mul_val;
                        zero       <= (mul_val == '0);
                        rd_out     <= m_rd;
                        store_data <= m_store;
                    end
                    S_DIV: begin
                        if (div_last) begin
                            out_valid  <= 1'b1;
                            alu_result <= div_val;
                            zero       <= (div_val == '0);
                            rd_out     <= m_rd;
                            store_data <= m_store;
                            cnt        <= '0;
                        end else begin
                            div_rem <= rem_step;
                            div_quo <= quo_step;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed self-checking bench for ex_stage_pipe
module tb_ex_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, alu_src;
    logic [1:0]  alu_op, forwardA, forwardB;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data, rs2_data, imm, ex_mem_alu_result, write_data;
    logic [4:0]  rd_in, rd_out;
    logic        ex_stall, out_valid, zero;
    logic [31:0] alu_result, store_data;

    int errors = 0;
    int checks = 0;

    ex_stage_pipe #(.XLEN(32), .ENABLE_M(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .alu_src(alu_src),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_alu_result(ex_mem_alu_result), .write_data(write_data),
        .rd_in(rd_in), .ex_stall(ex_stall), .out_valid(out_valid),
        .alu_result(alu_result), .store_data(store_data), .zero(zero), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input logic src,
                          input logic [31:0] im);
        alu_op = op; funct3 = f3; funct7 = f7;
        rs1_data = a; rs2_data = b; alu_src = src; imm = im;
    endtask

    // Presents the op, holds it while stalled, and measures stall cycles and edges to out_valid
    task automatic run_op(input string tag, input int exp_stall, input int exp_edges,
                          input logic [31:0] exp_res);
        int st = 0;
        int ed = 0;
        in_valid = 1'b1;
        #1;
        if (ex_stall) st++;
        @(posedge clk);
        ed = 1;
        while (ed < 40) begin
            #1;
            if (out_valid) break;
            if (ex_stall) st++; else in_valid = 1'b0;
            @(posedge clk);
            ed++;
        end
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_edges"}, ed, exp_edges);
        chk({tag, "_stall"}, st, exp_stall);
        chk({tag, "_result"}, alu_result, exp_res);
        tick();
        chk({tag, "_pulse"}, out_valid, 1'b0);
    endtask

    initial begin
        int ov;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
        forwardA = 2'b00; forwardB = 2'b00;
        ex_mem_alu_result = 32'd0; write_data = 32'd0; rd_in = 5'd7;
        set_op(2'b10, 3'b100, 7'b0000001, 32'd100, 32'd7, 1'b0, 32'd0);
        #1;
        chk("stall_in_reset", ex_stall, 1'b0);
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_store", store_data, 32'd0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_rd", rd_out, 5'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ADD with immediate; forwardB must not override the immediate
        set_op(2'b00, 3'b000, 7'd0, 32'd5, 32'd3, 1'b1, 32'd7);
        forwardB = 2'b10; ex_mem_alu_result = 32'd100; rd_in = 5'd3; in_valid = 1'b1;
        #1;
        chk("add_stall", ex_stall, 1'b0);
        tick();
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", alu_result, 32'd12);
        chk("add_rd", rd_out, 5'd3);
        chk("add_store", store_data, 32'd100);
        in_valid = 1'b0;
        tick();
        chk("bubble_valid", out_valid, 1'b0);
        chk("bubble_hold", alu_result, 32'd12);

        // SUB with forwarded rs1
        set_op(2'b01, 3'b000, 7'd0, 32'd1, 32'd9, 1'b0, 32'd0);
        forwardA = 2'b10; forwardB = 2'b00; ex_mem_alu_result = 32'd9; in_valid = 1'b1;
        tick();
        chk("sub_result", alu_result, 32'd0);
        chk("sub_zero", zero, 1'b1);
        forwardA = 2'b00;

        // Back-to-back R/I-type ops
        set_op(2'b10, 3'b101, 7'b0100000, 32'hF000_0000, 32'd4, 1'b0, 32'd0);
        tick();
        chk("sra", alu_result, 32'hFF00_0000);
        chk("sra_zero", zero, 1'b0);
        set_op(2'b10, 3'b001, 7'd0, 32'd1, 32'd33, 1'b0, 32'd0);
        tick();
        chk("sll_shamt", alu_result, 32'd2);
        set_op(2'b10, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        tick();
        chk("slt", alu_result, 32'd1);
        set_op(2'b10, 3'b011, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        tick();
        chk("sltu", alu_result, 32'd0);
        set_op(2'b11, 3'b000, 7'b0100000, 32'd10, 32'd99, 1'b1, 32'd3);
        tick();
        chk("addi", alu_result, 32'd13);
        set_op(2'b10, 3'b100, 7'd0, 32'd0, 32'h0F, 1'b0, 32'd0);
        forwardA = 2'b01; write_data = 32'hFF;
        tick();
        chk("xor_fwd_wd", alu_result, 32'hF0);
        forwardA = 2'b00; in_valid = 1'b0;
        tick();

        // Multiply
        set_op(2'b10, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run_op("mulhu", 1, 2, 32'hFFFF_FFFE);
        set_op(2'b10, 3'b000, 7'b0000001, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd0);
        run_op("mul", 1, 2, 32'hFFFF_FFEB);
        set_op(2'b10, 3'b001, 7'b0000001, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0);
        run_op("mulh", 1, 2, 32'h4000_0000);

        // Divide, including overflow and divide-by-zero
        set_op(2'b10, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run_op("div_ovf", 32, 33, 32'h8000_0000);
        set_op(2'b10, 3'b110, 7'b0000001, 32'd7, 32'd0, 1'b0, 32'd0);
        run_op("rem_dbz", 32, 33, 32'd7);
        set_op(2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
        run_op("div_neg", 32, 33, 32'hFFFF_FFFD);
        set_op(2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
        run_op("rem_neg", 32, 33, 32'hFFFF_FFFF);
        set_op(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7, 1'b0, 32'd0);
        run_op("divu", 32, 33, 32'd14);

        // Flush during DIVU cycle 10
        set_op(2'b10, 3'b101, 7'b0000001, 32'd1000, 32'd3, 1'b0, 32'd0);
        in_valid = 1'b1;
        tick();
        repeat (8) tick();
        chk("flush_pre_stall", ex_stall, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_stall", ex_stall, 1'b0);
        tick();
        chk("flush_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        ov = 0;
        repeat (40) begin
            tick();
            if (out_valid) ov++;
        end
        chk("flush_no_valid", ov, 0);
        set_op(2'b00, 3'b000, 7'd0, 32'd20, 32'd22, 1'b0, 32'd0);
        in_valid = 1'b1; flush = 1'b1;
        tick();
        chk("flush_wins", out_valid, 1'b0);
        flush = 1'b0;
        tick();
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_add", alu_result, 32'd42);
        in_valid = 1'b0;
        tick();

        // Reset mid-divide
        set_op(2'b10, 3'b101, 7'b0000001, 32'd1000, 32'd3, 1'b0, 32'd0);
        in_valid = 1'b1;
        tick();
        repeat (5) tick();
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_stall", ex_stall, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_result", alu_result, 32'd0);
        chk("rst_mid_rd", rd_out, 5'd0);
        ov = 0;
        repeat (40) begin
            tick();
            if (out_valid) ov++;
        end
        chk("rst_mid_no_valid", ov, 0);
        set_op(2'b10, 3'b110, 7'd0, 32'h00F0, 32'h0F00, 1'b0, 32'd0);
        rd_in = 5'd9; in_valid = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_or", alu_result, 32'h0FF0);
        chk("post_rst_rd", rd_out, 5'd9);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
